cfg_regfile_v2: RTL and testbench

Parametrised configuration/status register file for the system-control path. It generalises the fixed 16×8 register file to:
- arbitrary width and depth
- per-register reset values and read-only protection
- a sticky hardware status register with write-1-to-clear
- access-error reporting

The first `NUM_EXPORT` registers drive downstream blocks (UART/ALU/clock-divider configuration) directly.

---
 rtl/cfg_regfile_pkg.sv | 36 +++
 rtl/sticky_status_reg.sv | 33 +++
 rtl/cfg_regfile_v2.sv | 113 +++++++++++
 tb/tb_cfg_regfile_v2.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_regfile_pkg.sv
// Shared defaults for the configuration register file: widths, the default reset
// image, named register addresses and a reset-slice helper.
package cfg_regfile_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_NUM_EXPORT = 4;

  // Upper bounds for the slice helper; any legal instance must fit inside these.
  localparam int MAX_DATA_WIDTH = 64;
  localparam int MAX_RESET_BITS = 2048;

  localparam logic [DEF_DEPTH*DEF_DATA_WIDTH-1:0] DEF_RESET_VALUES =
    {96'h0, 8'h20, 8'h81, 16'h0000};

  localparam logic [DEF_ADDR_WIDTH-1:0] ADDR_REG0   = 4'h0;
  localparam logic [DEF_ADDR_WIDTH-1:0] ADDR_REG1   = 4'h1;
  localparam logic [DEF_ADDR_WIDTH-1:0] ADDR_REG2   = 4'h2;
  localparam logic [DEF_ADDR_WIDTH-1:0] ADDR_REG3   = 4'h3;
  localparam logic [DEF_ADDR_WIDTH-1:0] ADDR_STATUS = 4'hF;

  function automatic logic [MAX_DATA_WIDTH-1:0] reset_slice(
    input logic [MAX_RESET_BITS-1:0] values,
    input int                        idx,
    input int                        width
  );
    logic [MAX_RESET_BITS-1:0] shifted;
    logic [MAX_DATA_WIDTH-1:0] mask;
    shifted = values >> (idx * width);
    mask    = (width >= MAX_DATA_WIDTH) ? '1
            : ((MAX_DATA_WIDTH'(1) << width) - MAX_DATA_WIDTH'(1));
    return shifted[MAX_DATA_WIDTH-1:0] & mask;
  endfunction

endpackage

// File: rtl/sticky_status_reg.sv
// Sticky hardware status register: per-bit set pulses accumulate, bus writes
// clear with write-1-to-clear, and a same-cycle set beats the clear.
module sticky_status_reg
  import cfg_regfile_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [WIDTH-1:0] set,
  input  logic             clr_en,
  input  logic [WIDTH-1:0] clr_mask,
  output logic [WIDTH-1:0] status
);

  logic [WIDTH-1:0] status_reg;
  logic [WIDTH-1:0] status_next;

  always_comb begin
    status_next = (status_reg & ~(clr_en ? clr_mask : {WIDTH{1'b0}})) | set;
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      status_reg <= '0;
    end else begin
      status_reg <= status_next;
    end
  end

  assign status = status_reg;

endmodule

// File: rtl/cfg_regfile_v2.sv
// Parametrised configuration/status register file with per-register reset
// values, read-only protection, a sticky status register and access errors.
module cfg_regfile_v2
  import cfg_regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int NUM_EXPORT = DEF_NUM_EXPORT,
  parameter logic [DEPTH*DATA_WIDTH-1:0] RESET_VALUES =
    (DEPTH*DATA_WIDTH)'(DEF_RESET_VALUES),
  parameter logic [DEPTH-1:0] RO_MASK = '0,
  parameter int STATUS_ADDR = DEPTH - 1
) (
  input  logic                             clk,
  input  logic                             RST,
  input  logic                             WrEn,
  input  logic                             RdEn,
  input  logic [ADDR_WIDTH-1:0]            Address,
  input  logic [DATA_WIDTH-1:0]            WrData,
  input  logic [DATA_WIDTH-1:0]            StatusSet,
  output logic [DATA_WIDTH-1:0]            RdData,
  output logic                             RdData_Valid,
  output logic                             AccErr,
  output logic [NUM_EXPORT*DATA_WIDTH-1:0] REG_OUT
);

  localparam logic [MAX_RESET_BITS-1:0] RESET_EXT = MAX_RESET_BITS'(RESET_VALUES);

  logic                  wr_only;
  logic                  rd_only;
  logic                  both_req;
  logic                  addr_ok;
  logic                  ro_hit;
  logic                  acc_err_next;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] reg_q [DEPTH];

  logic [DATA_WIDTH-1:0] rd_data_reg;
  logic                  rd_valid_reg;
  logic                  acc_err_reg;

  assign wr_only  = WrEn & ~RdEn;
  assign rd_only  = RdEn & ~WrEn;
  assign both_req = WrEn & RdEn;
  assign addr_ok  = (32'(Address) < DEPTH);
  // The status register is never treated as read-only: its writes are W1C.
  assign ro_hit   = addr_ok && RO_MASK[Address] && (32'(Address) != STATUS_ADDR);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      if (gi == STATUS_ADDR) begin : g_status
        logic [DATA_WIDTH-1:0] status_q;
        sticky_status_reg #(
          .WIDTH (DATA_WIDTH)
        ) u_status (
          .clk      (clk),
          .RST      (RST),
          .set      (StatusSet),
          .clr_en   (wr_only && (Address == ADDR_WIDTH'(gi))),
          .clr_mask (WrData),
          .status   (status_q)
        );
        assign reg_q[gi] = status_q;
      end else if (RO_MASK[gi]) begin : g_ro
        localparam logic [DATA_WIDTH-1:0] RST_VAL =
          DATA_WIDTH'(reset_slice(RESET_EXT, gi, DATA_WIDTH));
        assign reg_q[gi] = RST_VAL;
      end else begin : g_rw
        localparam logic [DATA_WIDTH-1:0] RST_VAL =
          DATA_WIDTH'(reset_slice(RESET_EXT, gi, DATA_WIDTH));
        logic [DATA_WIDTH-1:0] cfg_reg;
        always_ff @(posedge clk or negedge RST) begin
          if (!RST) begin
            cfg_reg <= RST_VAL;
          end else if (wr_only && (Address == ADDR_WIDTH'(gi))) begin
            cfg_reg <= WrData;
          end
        end
        assign reg_q[gi] = cfg_reg;
      end
    end

    for (gi = 0; gi < NUM_EXPORT; gi++) begin : g_export
      assign REG_OUT[gi*DATA_WIDTH +: DATA_WIDTH] = reg_q[gi];
    end
  endgenerate

  assign rd_word      = addr_ok ? reg_q[Address] : '0;
  assign acc_err_next = both_req
                      | (rd_only & ~addr_ok)
                      | (wr_only & (~addr_ok | ro_hit));

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
      acc_err_reg  <= 1'b0;
    end else begin
      rd_valid_reg <= rd_only;
      acc_err_reg  <= acc_err_next;
      if (rd_only) begin
        rd_data_reg <= rd_word;
      end
    end
  end

  assign RdData       = rd_data_reg;
  assign RdData_Valid = rd_valid_reg;
  assign AccErr       = acc_err_reg;

endmodule

// File: tb/tb_cfg_regfile_v2.sv
// Self-checking bench for cfg_regfile_v2 (DEPTH=12, reg2 read-only) against a
// behavioural model of the register map.
module tb_cfg_regfile_v2;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 12;
  localparam int NEXP  = 4;
  localparam int STAT  = 11;
  localparam logic [DEPTH-1:0] RO = 12'h004;

  logic            clk = 1'b0;
  logic            RST;
  logic            WrEn;
  logic            RdEn;
  logic [AW-1:0]   Address;
  logic [DW-1:0]   WrData;
  logic [DW-1:0]   StatusSet;
  logic [DW-1:0]   RdData;
  logic            RdData_Valid;
  logic            AccErr;
  logic [NEXP*DW-1:0] REG_OUT;

  always #5 clk = ~clk;

  cfg_regfile_v2 #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .NUM_EXPORT (NEXP),
    .RO_MASK    (RO)
  ) dut (
    .clk          (clk),
    .RST          (RST),
    .WrEn         (WrEn),
    .RdEn         (RdEn),
    .Address      (Address),
    .WrData       (WrData),
    .StatusSet    (StatusSet),
    .RdData       (RdData),
    .RdData_Valid (RdData_Valid),
    .AccErr       (AccErr),
    .REG_OUT      (REG_OUT)
  );

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] m_regs [DEPTH];
  logic [DW-1:0] exp_rd;
  logic          exp_valid;
  logic          exp_err;

  function automatic logic [NEXP*DW-1:0] exp_out();
    return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_regs[i] = 8'h00;
    m_regs[2] = 8'h81;
    m_regs[3] = 8'h20;
    exp_rd    = 8'h00;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
  endtask

  // Drive one bus cycle, advance the model, and return 1 ns after the edge.
  task automatic step(input logic wr, input logic rd, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input logic [DW-1:0] set);
    int ai;
    WrEn = wr; RdEn = rd; Address = a; WrData = wd; StatusSet = set;
    ai = int'(a);
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    if (wr && rd) begin
      exp_err = 1'b1;
    end else if (rd) begin
      exp_valid = 1'b1;
      if (ai < DEPTH) exp_rd = m_regs[ai];
      else begin exp_rd = 8'h00; exp_err = 1'b1; end
    end else if (wr) begin
      if (ai >= DEPTH || RO[ai]) exp_err = 1'b1;
      else if (ai == STAT) m_regs[ai] = m_regs[ai] & ~wd;
      else m_regs[ai] = wd;
    end
    m_regs[STAT] = m_regs[STAT] | set;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    RdEn = 1'b1; WrEn = 1'b0; Address = 4'd1;
    #2 RST = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({RdData, RdData_Valid, AccErr, REG_OUT} !== {8'h00, 1'b0, 1'b0, 32'h2081_0000}) begin
      errors++;
      $display("FAIL reset_async: got rd=%h v=%b err=%b out=%h, need rd=00 v=0 err=0 out=20810000",
               RdData, RdData_Valid, AccErr, REG_OUT);
    end
    RdEn = 1'b0;
    @(posedge clk);
    #1 RST = 1'b1;
    step(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
    checks++;
    if ({RdData, RdData_Valid, AccErr, REG_OUT} !== {exp_rd, exp_valid, exp_err, exp_out()}) begin
      errors++;
      $display("FAIL reset_release: got rd=%h v=%b err=%b out=%h, need rd=%h v=%b err=%b out=%h",
               RdData, RdData_Valid, AccErr, REG_OUT, exp_rd, exp_valid, exp_err, exp_out());
    end
    step(1'b0, 1'b1, 4'(STAT), 8'h00, 8'h00);
    checks++;
    if ({RdData, RdData_Valid} !== {8'h00, 1'b1}) begin
      errors++;
      $display("FAIL reset_status: got rd=%h v=%b, need rd=00 v=1", RdData, RdData_Valid);
    end
    $display("reset: out=%h status_rd=%h", REG_OUT, RdData);
  endtask

  task automatic test_write_readback();
    step(1'b1, 1'b0, 4'd1, 8'hA5, 8'h00);
    checks++;
    if (REG_OUT[15:8] !== 8'hA5) begin
      errors++;
      $display("FAIL wr_reg_out: got %h, need a5", REG_OUT[15:8]);
    end
    step(1'b0, 1'b1, 4'd1, 8'h00, 8'h00);
    checks++;
    if ({RdData, RdData_Valid, AccErr} !== {8'hA5, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL wr_readback: got rd=%h v=%b err=%b, need rd=a5 v=1 err=0",
               RdData, RdData_Valid, AccErr);
    end
    step(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
    checks++;
    if ({RdData, RdData_Valid} !== {8'hA5, 1'b0}) begin
      errors++;
      $display("FAIL idle_hold: got rd=%h v=%b, need rd=a5 v=0", RdData, RdData_Valid);
    end
    $display("write_readback: rd=%h out=%h", RdData, REG_OUT);
  endtask

  task automatic test_read_only();
    step(1'b1, 1'b0, 4'd2, 8'hFF, 8'h00);
    checks++;
    if ({AccErr, RdData_Valid, REG_OUT[23:16]} !== {1'b1, 1'b0, 8'h81}) begin
      errors++;
      $display("FAIL ro_write: got err=%b v=%b reg2=%h, need err=1 v=0 reg2=81",
               AccErr, RdData_Valid, REG_OUT[23:16]);
    end
    step(1'b0, 1'b1, 4'd2, 8'h00, 8'h00);
    checks++;
    if ({RdData, RdData_Valid, AccErr} !== {8'h81, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL ro_readback: got rd=%h v=%b err=%b, need rd=81 v=1 err=0",
               RdData, RdData_Valid, AccErr);
    end
    $display("read_only: reg2=%h", RdData);
  endtask

  task automatic test_status_w1c();
    logic [DW-1:0] need [4] = '{8'h05, 8'h01, 8'h01, 8'h03};
    step(1'b0, 1'b0, 4'd0, 8'h00, 8'h05);
    step(1'b0, 1'b1, 4'(STAT), 8'h00, 8'h00);
    checks++;
    if (RdData !== need[0]) begin
      errors++;
      $display("FAIL status_set: got %h, need %h", RdData, need[0]);
    end
    step(1'b1, 1'b0, 4'(STAT), 8'h05, 8'h01);
    checks++;
    if (AccErr !== 1'b0) begin
      errors++;
      $display("FAIL status_w1c_err: got err=%b, need 0", AccErr);
    end
    step(1'b0, 1'b1, 4'(STAT), 8'h00, 8'h02);
    checks++;
    if (RdData !== need[1]) begin
      errors++;
      $display("FAIL status_set_wins: got %h, need %h", RdData, need[1]);
    end
    step(1'b0, 1'b1, 4'(STAT), 8'h00, 8'h00);
    checks++;
    if (RdData !== need[3]) begin
      errors++;
      $display("FAIL status_pre_merge: got %h, need %h", RdData, need[3]);
    end
    $display("status_w1c: status=%h", RdData);
  endtask

  task automatic test_illegal();
    step(1'b0, 1'b1, 4'd14, 8'h00, 8'h00);
    checks++;
    if ({RdData, RdData_Valid, AccErr} !== {8'h00, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL oob_read: got rd=%h v=%b err=%b, need rd=00 v=1 err=1",
               RdData, RdData_Valid, AccErr);
    end
    step(1'b1, 1'b1, 4'd1, 8'h3C, 8'h00);
    checks++;
    if ({RdData, RdData_Valid, AccErr, REG_OUT} !== {8'h00, 1'b0, 1'b1, exp_out()}) begin
      errors++;
      $display("FAIL both_req: got rd=%h v=%b err=%b out=%h, need rd=00 v=0 err=1 out=%h",
               RdData, RdData_Valid, AccErr, REG_OUT, exp_out());
    end
    step(1'b1, 1'b0, 4'd13, 8'h77, 8'h00);
    checks++;
    if ({RdData_Valid, AccErr, REG_OUT} !== {1'b0, 1'b1, exp_out()}) begin
      errors++;
      $display("FAIL oob_write: got v=%b err=%b out=%h, need v=0 err=1 out=%h",
               RdData_Valid, AccErr, REG_OUT, exp_out());
    end
    step(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
    checks++;
    if ({RdData_Valid, AccErr} !== 2'b00) begin
      errors++;
      $display("FAIL err_clears: got v=%b err=%b, need v=0 err=0", RdData_Valid, AccErr);
    end
    $display("illegal: out=%h", REG_OUT);
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b0, 4'd0, 8'h3E, 8'h00);
    for (int a = 0; a < 4; a++) begin
      step(1'b0, 1'b1, 4'(a), 8'h00, 8'h00);
      checks++;
      if ({RdData, RdData_Valid, AccErr} !== {exp_rd, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL b2b_read%0d: got rd=%h v=%b err=%b, need rd=%h v=1 err=0",
                 a, RdData, RdData_Valid, AccErr, exp_rd);
      end
      $display("b2b: addr=%0d rd=%h v=%b", a, RdData, RdData_Valid);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int n = 0; n < 400; n++) begin
      int r;
      logic [DW-1:0] set;
      r   = $urandom_range(0, 9);
      set = ($urandom_range(0, 3) == 0) ? DW'($urandom) : 8'h00;
      step(r < 4 || r == 8, (r >= 4 && r < 8) || r == 8,
           AW'($urandom_range(0, 15)), DW'($urandom), set);
      checks++;
      if ({RdData, RdData_Valid, AccErr, REG_OUT} !== {exp_rd, exp_valid, exp_err, exp_out()}) begin
        errors++;
        bad++;
        $display("FAIL random%0d: got rd=%h v=%b err=%b out=%h, need rd=%h v=%b err=%b out=%h",
                 n, RdData, RdData_Valid, AccErr, REG_OUT, exp_rd, exp_valid, exp_err, exp_out());
      end
    end
    $display("random: 400 cycles, %0d mismatched", bad);
  endtask

  initial begin
    RST = 1'b0; WrEn = 1'b0; RdEn = 1'b0;
    Address = '0; WrData = '0; StatusSet = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 RST = 1'b1;
    test_reset();
    test_write_readback();
    test_read_only();
    test_status_w1c();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
